// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int WIDTH_DEF     = 4;
    localparam int CNT_W_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int PTR_W         = $clog2(N_REQ_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority encoder: first set bit of req at or above ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          vld
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (int'(ptr) + i) % N;
            if (en && !vld && req[k]) begin
                vld       = 1'b1;
                idx       = PW'(k);
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the synchronous FIFO; never writes while full.
// Optional burst locking of one requester is enabled with FIFO_ARB_BURST_LOCK_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]       gnt_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_en_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic                   busy_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
        return (int'(v) == N_REQ - 1) ? '0 : v + PW'(1);
    endfunction

    // Reset and full both kill the grant in the same cycle.
    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .en     (!rst_i && !fifo_full_i),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    assign gnt_o        = pick_oh;
    assign fifo_wr_en_o = pick_vld;
    assign fifo_wdata_o = pick_vld ? wdata_i[int'(pick_idx)*WIDTH +: WIDTH] : '0;
    assign busy_o       = (|req_i) && !rst_i;

`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    lock_q, lock_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic [N_REQ-1:0] lock_mask;

    always_comb begin
        lock_mask         = '0;
        lock_mask[lock_q] = 1'b1;
    end

    assign pick_req = (state_q == LOCK) ? (req_i & lock_mask) : req_i;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        beats_d = beats_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    lock_d = pick_idx;
                    if (MAX_BURST <= 1) begin
                        ptr_d = ptr_inc(pick_idx);
                    end else begin
                        state_d = LOCK;
                        beats_d = BW'(1);
                    end
                end
            end
            LOCK: begin
                // Full cycles fall through both branches and leave the lock untouched.
                if (!req_i[lock_q]) begin
                    state_d = IDLE;
                    beats_d = '0;
                    ptr_d   = ptr_inc(lock_q);
                end else if (pick_vld) begin
                    if (int'(beats_q) + 1 >= MAX_BURST) begin
                        state_d = IDLE;
                        beats_d = '0;
                        ptr_d   = ptr_inc(lock_q);
                    end else begin
                        beats_d = beats_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lock_q  <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            beats_q <= beats_d;
        end
    end
`else
    assign pick_req = req_i;

    always_comb begin
        ptr_d = ptr_q;
        if (pick_vld) ptr_d = ptr_inc(pick_idx);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            stall_cnt_o <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (busy_o && fifo_full_i && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default build): grant rotation, full backpressure,
// stall saturation and mid-operation reset, with written words checked against a scoreboard.
module tb_fifo_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [15:0] wdata_i;
    logic [3:0]  gnt_o;
    logic        fifo_full_i;
    logic        fifo_wr_en_o;
    logic [3:0]  fifo_wdata_o;
    logic [7:0]  stall_cnt_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] sb[$];
    logic [3:0] word_tbl[4];

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(4), .CNT_W(8), .MAX_BURST(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wdata_o (fifo_wdata_o),
        .stall_cnt_o  (stall_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock of stimulus: drive after the edge, check at the falling edge.
    task automatic step(input string tag, input logic [3:0] rq, input logic fl, input logic [3:0] eg);
        logic [3:0] exp_w;
        req_i       = rq;
        fifo_full_i = fl;
        if (eg != 4'b0) sb.push_back(word_tbl[oh2i(eg)]);
        @(negedge clk_i);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'(eg));
        chk({tag, "_wen"}, 32'(fifo_wr_en_o), 32'(|eg));
        chk({tag, "_busy"}, 32'(busy_o), 32'(|rq));
        if (fifo_wr_en_o) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected_write"}, 32'(fifo_wdata_o), 32'hDEAD);
            end else begin
                exp_w = sb.pop_front();
                chk({tag, "_wdata"}, 32'(fifo_wdata_o), 32'(exp_w));
            end
        end else begin
            chk({tag, "_wdata_idle"}, 32'(fifo_wdata_o), 32'h0);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        word_tbl[0] = 4'h1;
        word_tbl[1] = 4'h2;
        word_tbl[2] = 4'h3;
        word_tbl[3] = 4'h4;
        wdata_i     = {word_tbl[3], word_tbl[2], word_tbl[1], word_tbl[0]};
        rst_i       = 1'b1;
        req_i       = 4'b1111;
        fifo_full_i = 1'b0;

        // Reset forces everything quiet even with requests present.
        @(negedge clk_i);
        chk("rst_gnt",   32'(gnt_o), 32'h0);
        chk("rst_wen",   32'(fifo_wr_en_o), 32'h0);
        chk("rst_wdata", 32'(fifo_wdata_o), 32'h0);
        chk("rst_busy",  32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        chk("rst_stall", 32'(stall_cnt_o), 32'h0);
        rst_i = 1'b0;

        // All requesting: strict rotation starting at 0, wrapping 3->0.
        for (int r = 0; r < 2; r++) begin
            step("rr0", 4'b1111, 1'b0, 4'b0001);
            step("rr1", 4'b1111, 1'b0, 4'b0010);
            step("rr2", 4'b1111, 1'b0, 4'b0100);
            step("rr3", 4'b1111, 1'b0, 4'b1000);
        end
        chk("rr_stall", 32'(stall_cnt_o), 32'h0);

        // Lone requester 2 moves ptr to 3, so 3 wins next from a full set.
        step("solo2",    4'b0100, 1'b0, 4'b0100);
        step("after2",   4'b1111, 1'b0, 4'b1000);
        step("idle",     4'b0000, 1'b0, 4'b0000);

        // Backpressure: no grants while full, stall counts every busy cycle.
        for (int i = 0; i < 5; i++) step("full", 4'b0011, 1'b1, 4'b0000);
        chk("stall5", 32'(stall_cnt_o), 32'd5);
        step("unfull", 4'b0011, 1'b0, 4'b0001);
        chk("stall5_hold", 32'(stall_cnt_o), 32'd5);

        // Saturation at 255; ptr stays at 1 across the full period.
        for (int i = 0; i < 249; i++) step("sat", 4'b0001, 1'b1, 4'b0000);
        chk("stall254", 32'(stall_cnt_o), 32'd254);
        step("sat", 4'b0001, 1'b1, 4'b0000);
        chk("stall255", 32'(stall_cnt_o), 32'd255);
        for (int i = 0; i < 10; i++) step("sat", 4'b0011, 1'b1, 4'b0000);
        chk("stall_sticky", 32'(stall_cnt_o), 32'd255);
        step("held_ptr", 4'b0011, 1'b0, 4'b0010);
        step("held_ptr2", 4'b1001, 1'b0, 4'b1000);

        // Reset while requester 3 would be granted: grant suppressed that cycle.
        rst_i = 1'b1;
        req_i = 4'b1000;
        @(negedge clk_i);
        chk("midrst_gnt",  32'(gnt_o), 32'h0);
        chk("midrst_wen",  32'(fifo_wr_en_o), 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("midrst_stall", 32'(stall_cnt_o), 32'h0);
        step("post_rst", 4'b1111, 1'b0, 4'b0001);
        step("post_rst2", 4'b1100, 1'b0, 4'b0100);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
